// File: rtl/knn_vote.sv
// k-NN read-out and majority vote: sweeps sorter slots, fetches labels from a
// synchronous label RAM, tallies per-class votes and reports the winner.
module knn_vote #(
  parameter int W       = 32,
  parameter int HW_K    = 10,
  parameter int C_W     = 4,
  parameter int N_CLASS = 16,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      k,
  output logic [15:0]      sel,
  input  logic [W/4-1:0]   idx,
  output logic [W/4-1:0]   lbl_addr,
  input  logic [C_W-1:0]   lbl_data,
  output logic             busy,
  output logic             done,
  output logic [C_W-1:0]   class_out,
  output logic [CNT_W-1:0] votes_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SWEEP,
    S_DRAIN,
    S_SCAN,
    S_FIN
  } state_t;

  state_t           r_state;
  logic [15:0]      r_sel;
  logic [15:0]      r_kq;
  logic             r_pend;
  logic [CNT_W-1:0] r_vote [N_CLASS];
  logic [C_W-1:0]   r_ptr;
  logic [C_W-1:0]   r_best_c;
  logic [CNT_W-1:0] r_best_v;
  logic             r_busy;
  logic             r_done;
  logic [C_W-1:0]   r_class;
  logic [CNT_W-1:0] r_votes;

  logic [15:0]      w_kq;

  assign w_kq      = (k > 16'(HW_K)) ? 16'(HW_K) : k;
  assign lbl_addr  = idx;
  assign sel       = r_sel;
  assign busy      = r_busy;
  assign done      = r_done;
  assign class_out = r_class;
  assign votes_out = r_votes;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_sel    <= '0;
      r_kq     <= '0;
      r_pend   <= 1'b0;
      r_ptr    <= '0;
      r_best_c <= '0;
      r_best_v <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_class  <= '0;
      r_votes  <= '0;
      for (int unsigned c = 0; c < N_CLASS; c++) r_vote[c] <= '0;
    end else begin
      r_done <= 1'b0;
      r_pend <= 1'b0;
      // Label for the previous sweep slot arrives now; out-of-range labels match no counter.
      if (r_pend) begin
        for (int unsigned c = 0; c < N_CLASS; c++) begin
          if (lbl_data == C_W'(c) && r_vote[c] != '1) r_vote[c] <= r_vote[c] + 1'b1;
        end
      end
      case (r_state)
        S_IDLE: begin
          // A start coinciding with the done pulse is ignored.
          if (start && !r_done) begin
            r_kq     <= w_kq;
            r_sel    <= '0;
            r_best_c <= '0;
            r_best_v <= '0;
            r_busy   <= 1'b1;
            for (int unsigned c = 0; c < N_CLASS; c++) r_vote[c] <= '0;
            r_state  <= (w_kq == '0) ? S_FIN : S_SWEEP;
          end
        end
        S_SWEEP: begin
          r_pend <= 1'b1;
          if (r_sel == r_kq - 16'd1) begin
            r_sel   <= '0;
            r_state <= S_DRAIN;
          end else begin
            r_sel <= r_sel + 16'd1;
          end
        end
        S_DRAIN: begin
          r_ptr    <= '0;
          r_best_c <= '0;
          r_best_v <= '0;
          r_state  <= S_SCAN;
        end
        S_SCAN: begin
          if (r_vote[r_ptr] > r_best_v) begin
            r_best_c <= r_ptr;
            r_best_v <= r_vote[r_ptr];
          end
          if (r_ptr == C_W'(N_CLASS - 1)) r_state <= S_FIN;
          else                            r_ptr   <= r_ptr + 1'b1;
        end
        S_FIN: begin
          r_class <= r_best_c;
          r_votes <= r_best_v;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_knn_vote.sv
// Directed bench for knn_vote: sorter slots and label RAM are modelled here,
// expected classes, vote counts and latencies are hand-computed.
module tb_knn_vote;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] k;
  logic [15:0] sel;
  logic [7:0]  idx;
  logic [7:0]  lbl_addr;
  logic [3:0]  lbl_data;
  logic        busy;
  logic        done;
  logic [3:0]  class_out;
  logic [7:0]  votes_out;

  logic        start4;
  logic [15:0] k4;
  logic [15:0] sel4;
  logic [7:0]  idx4;
  logic [7:0]  lbl_addr4;
  logic [3:0]  lbl_data4;
  logic        busy4;
  logic        done4;
  logic [3:0]  class_out4;
  logic [7:0]  votes_out4;

  logic [7:0] slot    [0:9];
  logic [3:0] lbl_mem [0:255];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  knn_vote #(.W(32), .HW_K(10), .C_W(4), .N_CLASS(16), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .k(k), .sel(sel), .idx(idx),
    .lbl_addr(lbl_addr), .lbl_data(lbl_data), .busy(busy), .done(done),
    .class_out(class_out), .votes_out(votes_out)
  );

  knn_vote #(.W(32), .HW_K(10), .C_W(4), .N_CLASS(4), .CNT_W(8)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .k(k4), .sel(sel4), .idx(idx4),
    .lbl_addr(lbl_addr4), .lbl_data(lbl_data4), .busy(busy4), .done(done4),
    .class_out(class_out4), .votes_out(votes_out4)
  );

  assign idx  = (sel  < 16'd10) ? slot[sel[3:0]]  : 8'd0;
  assign idx4 = (sel4 < 16'd10) ? slot[sel4[3:0]] : 8'd0;

  always @(posedge clk) begin
    lbl_data  <= lbl_mem[lbl_addr];
    lbl_data4 <= lbl_mem[lbl_addr4];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Starts an operation on the main DUT and returns the cycle (start = 0) at which done is seen, -1 on timeout.
  task automatic do_op(input logic [15:0] kin, output int lat);
    if (done === 1'b1) tick;
    start = 1'b1;
    k     = kin;
    tick;
    start = 1'b0;
    lat   = 1;
    while (done !== 1'b1 && lat < 100) begin
      tick;
      lat++;
    end
    if (done !== 1'b1) lat = -1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sel !== 16'd0 || class_out !== 4'd0 || votes_out !== 8'd0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b sel=%0d class=%0d votes=%0d, required all 0",
               busy, done, sel, class_out, votes_out);
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_majority;
    int lat;
    slot[0] = 8'd3; slot[1] = 8'd7; slot[2] = 8'd9; slot[3] = 8'd1; slot[4] = 8'd2;
    lbl_mem[3] = 4'd2; lbl_mem[7] = 4'd5; lbl_mem[9] = 4'd2; lbl_mem[1] = 4'd2; lbl_mem[2] = 4'd5;
    do_op(16'd5, lat);
    checks++;
    if (lat != 24) begin errors++; $display("FAIL majority_latency: got %0d, required 24", lat); end
    checks++;
    if (class_out !== 4'd2 || votes_out !== 8'd3) begin
      errors++;
      $display("FAIL majority_result: got class %0d votes %0d, required class 2 votes 3", class_out, votes_out);
    end
  endtask

  task automatic test_tie;
    int lat;
    logic sel_ok;
    slot[0] = 8'd20; slot[1] = 8'd21; slot[2] = 8'd22; slot[3] = 8'd23;
    lbl_mem[20] = 4'd6; lbl_mem[21] = 4'd1; lbl_mem[22] = 4'd6; lbl_mem[23] = 4'd1;
    if (done === 1'b1) tick;
    start = 1'b1;
    k     = 16'd4;
    tick;
    start  = 1'b0;
    sel_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (sel !== 16'(i)) begin
        sel_ok = 1'b0;
        $display("FAIL tie_sel: cycle %0d sel=%0d, required %0d", i + 1, sel, i);
      end
      tick;
    end
    checks++;
    if (!sel_ok) errors++;
    lat = 5;
    while (done !== 1'b1 && lat < 100) begin tick; lat++; end
    checks++;
    if (lat != 23) begin errors++; $display("FAIL tie_latency: got %0d, required 23", lat); end
    checks++;
    if (class_out !== 4'd1 || votes_out !== 8'd2) begin
      errors++;
      $display("FAIL tie_result: got class %0d votes %0d, required class 1 votes 2", class_out, votes_out);
    end
  endtask

  task automatic test_clamp;
    int lat;
    logic sel_ok;
    logic [3:0] labs [0:9];
    labs = '{4'd5, 4'd5, 4'd5, 4'd7, 4'd7, 4'd7, 4'd1, 4'd1, 4'd1, 4'd7};
    for (int i = 0; i < 10; i++) begin
      slot[i] = 8'(10 + i);
      lbl_mem[10 + i] = labs[i];
    end
    if (done === 1'b1) tick;
    start = 1'b1;
    k     = 16'd20;
    tick;
    start  = 1'b0;
    sel_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (sel !== 16'(i)) begin
        sel_ok = 1'b0;
        $display("FAIL clamp_sel: cycle %0d sel=%0d, required %0d", i + 1, sel, i);
      end
      tick;
    end
    checks++;
    if (!sel_ok) errors++;
    checks++;
    if (sel !== 16'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL clamp_drain: sel=%0d busy=%b, required sel 0 busy 1", sel, busy);
    end
    lat = 11;
    while (done !== 1'b1 && lat < 100) begin tick; lat++; end
    checks++;
    if (lat != 29) begin errors++; $display("FAIL clamp_latency: got %0d, required 29", lat); end
    checks++;
    if (class_out !== 4'd7 || votes_out !== 8'd4) begin
      errors++;
      $display("FAIL clamp_result: got class %0d votes %0d, required class 7 votes 4", class_out, votes_out);
    end
  endtask

  task automatic test_k_zero;
    int lat;
    do_op(16'd0, lat);
    checks++;
    if (lat != 2) begin errors++; $display("FAIL k0_latency: got %0d, required 2", lat); end
    checks++;
    if (class_out !== 4'd0 || votes_out !== 8'd0) begin
      errors++;
      $display("FAIL k0_result: got class %0d votes %0d, required class 0 votes 0", class_out, votes_out);
    end
  endtask

  task automatic test_out_of_range;
    int lat;
    slot[0] = 8'd30; slot[1] = 8'd31; slot[2] = 8'd32;
    lbl_mem[30] = 4'd9; lbl_mem[31] = 4'd3; lbl_mem[32] = 4'd3;
    tick;
    start4 = 1'b1;
    k4     = 16'd3;
    tick;
    start4 = 1'b0;
    lat    = 1;
    while (done4 !== 1'b1 && lat < 100) begin tick; lat++; end
    checks++;
    if (lat != 10) begin errors++; $display("FAIL oor_latency: got %0d, required 10", lat); end
    checks++;
    if (class_out4 !== 4'd3 || votes_out4 !== 8'd2) begin
      errors++;
      $display("FAIL oor_result: got class %0d votes %0d, required class 3 votes 2", class_out4, votes_out4);
    end
  endtask

  task automatic test_busy_protect;
    int ndone = 0;
    int first = -1;
    slot[0] = 8'd3; slot[1] = 8'd7; slot[2] = 8'd9; slot[3] = 8'd1; slot[4] = 8'd2;
    tick;
    start = 1'b1;
    k     = 16'd5;
    tick;
    for (int n = 1; n <= 40; n++) begin
      start = (n == 5);
      if (n == 1) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_high: got %b, required 1", busy); end
      end
      if (done === 1'b1) begin
        ndone++;
        if (first < 0) first = n;
      end
      tick;
    end
    start = 1'b0;
    checks++;
    if (ndone != 1 || first != 24) begin
      errors++;
      $display("FAIL busy_restart: done pulses %0d first at %0d, required 1 pulse at 24", ndone, first);
    end
    checks++;
    if (class_out !== 4'd2 || votes_out !== 8'd3) begin
      errors++;
      $display("FAIL busy_result: got class %0d votes %0d, required class 2 votes 3", class_out, votes_out);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    slot[0] = 8'd20; slot[1] = 8'd21; slot[2] = 8'd22; slot[3] = 8'd23;
    do_op(16'd4, lat);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_at_done: got %b, required 0", busy); end
    start = 1'b1;
    k     = 16'd4;
    tick;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_start_on_done: busy %b, required 0", busy); end
    tick;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy %b, required 1", busy); end
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin tick; lat++; end
    checks++;
    if (lat != 23) begin errors++; $display("FAIL b2b_latency: got %0d, required 23", lat); end
    checks++;
    if (class_out !== 4'd1 || votes_out !== 8'd2) begin
      errors++;
      $display("FAIL b2b_result: got class %0d votes %0d, required class 1 votes 2", class_out, votes_out);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    for (int i = 0; i < 10; i++) slot[i] = 8'(10 + i);
    tick;
    start = 1'b1;
    k     = 16'd10;
    tick;
    start = 1'b0;
    repeat (3) tick;
    checks++;
    if (sel !== 16'd3) begin errors++; $display("FAIL rstmid_sel_before: got %0d, required 3", sel); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || sel !== 16'd0 || class_out !== 4'd0 || votes_out !== 8'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_state: busy=%b sel=%0d class=%0d votes=%0d done=%b, required all 0",
               busy, sel, class_out, votes_out, done);
    end
    slot[0] = 8'd40; slot[1] = 8'd41;
    lbl_mem[40] = 4'd4; lbl_mem[41] = 4'd4;
    do_op(16'd2, lat);
    checks++;
    if (lat != 21) begin errors++; $display("FAIL rstmid_latency: got %0d, required 21", lat); end
    checks++;
    if (class_out !== 4'd4 || votes_out !== 8'd2) begin
      errors++;
      $display("FAIL rstmid_result: got class %0d votes %0d, required class 4 votes 2", class_out, votes_out);
    end
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    k      = '0;
    start4 = 1'b0;
    k4     = '0;
    for (int i = 0; i < 10; i++)  slot[i] = '0;
    for (int i = 0; i < 256; i++) lbl_mem[i] = '0;
    test_reset;
    test_majority;
    test_tie;
    test_clamp;
    test_k_zero;
    test_out_of_range;
    test_busy_protect;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
